// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Requester-side bundle for the shared-ALU arbiter: request
//               handshake, ALU operand/select fields and response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] dataA;
   logic [XLEN-1:0] dataB;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imm;
   logic            Asel;
   logic            Bsel;
   logic [3:0]      ALUSel;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_result;

   // Requester side
   modport master (
      output req_valid, dataA, dataB, pc, imm, Asel, Bsel, ALUSel, resp_ready,
      input  req_ready, resp_valid, resp_result
   );

   // Arbiter side
   modport slave (
      input  req_valid, dataA, dataB, pc, imm, Asel, Bsel, ALUSel, resp_ready,
      output req_ready, resp_valid, resp_result
   );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters, with a one-deep response register per requester
//               and a saturating grant counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   alu_share_arbiter_if.slave    r0,
   alu_share_arbiter_if.slave    r1,
   output logic [XLEN-1:0]       alu_dataA,
   output logic [XLEN-1:0]       alu_dataB,
   output logic [XLEN-1:0]       alu_pc,
   output logic [XLEN-1:0]       alu_imm,
   output logic                  alu_Asel,
   output logic                  alu_Bsel,
   output logic [3:0]            alu_ALUSel,
   input  wire logic [XLEN-1:0]  alu_result,
   output logic [CNT_W-1:0]      op_count
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic             r_prio;          // 0: r0 favoured on a tie, 1: r1 favoured
   logic             r_resp_valid0;
   logic             r_resp_valid1;
   logic [XLEN-1:0]  r_resp_result0;
   logic [XLEN-1:0]  r_resp_result1;
   logic [CNT_W-1:0] r_op_count;

   logic             w_elig0;
   logic             w_elig1;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_any_grant;

   // Eligibility and grant; reset forces no grant so the ALU ports read zero
   always_comb begin
      w_elig0  = r0.req_valid && (!r_resp_valid0 || r0.resp_ready);
      w_elig1  = r1.req_valid && (!r_resp_valid1 || r1.resp_ready);
      w_grant0 = rst_n && w_elig0 && (!w_elig1 || !r_prio);
      w_grant1 = rst_n && w_elig1 && (!w_elig0 ||  r_prio);
      w_any_grant = w_grant0 || w_grant1;
   end

   assign r0.req_ready   = w_grant0;
   assign r1.req_ready   = w_grant1;
   assign r0.resp_valid  = r_resp_valid0;
   assign r1.resp_valid  = r_resp_valid1;
   assign r0.resp_result = r_resp_result0;
   assign r1.resp_result = r_resp_result1;
   assign op_count       = r_op_count;

   // Steer the granted requester's fields onto the ALU, zeros when idle
   always_comb begin
      alu_dataA  = '0;
      alu_dataB  = '0;
      alu_pc     = '0;
      alu_imm    = '0;
      alu_Asel   = 1'b0;
      alu_Bsel   = 1'b0;
      alu_ALUSel = 4'd0;
      if (w_grant0) begin
         alu_dataA  = r0.dataA;
         alu_dataB  = r0.dataB;
         alu_pc     = r0.pc;
         alu_imm    = r0.imm;
         alu_Asel   = r0.Asel;
         alu_Bsel   = r0.Bsel;
         alu_ALUSel = r0.ALUSel;
      end else if (w_grant1) begin
         alu_dataA  = r1.dataA;
         alu_dataB  = r1.dataB;
         alu_pc     = r1.pc;
         alu_imm    = r1.imm;
         alu_Asel   = r1.Asel;
         alu_Bsel   = r1.Bsel;
         alu_ALUSel = r1.ALUSel;
      end
   end

   // Round-robin pointer: after serving N, favour the other requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (w_grant0) begin
         r_prio <= 1'b1;
      end else if (w_grant1) begin
         r_prio <= 1'b0;
      end
   end

   // Response register for r0: a new grant wins over a drain in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid0  <= 1'b0;
         r_resp_result0 <= '0;
      end else if (w_grant0) begin
         r_resp_valid0  <= 1'b1;
         r_resp_result0 <= alu_result;
      end else if (r0.resp_ready) begin
         r_resp_valid0  <= 1'b0;
      end
   end

   // Response register for r1: same policy as r0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid1  <= 1'b0;
         r_resp_result1 <= '0;
      end else if (w_grant1) begin
         r_resp_valid1  <= 1'b1;
         r_resp_result1 <= alu_result;
      end else if (r1.resp_ready) begin
         r_resp_valid1  <= 1'b0;
      end
   end

   // Saturating grant counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_any_grant && (r_op_count != c_CNT_MAX)) begin
         r_op_count <= r_op_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter with a
//               small reference ALU (0 add, 1 sub, 2 and, 3 or, 4 xor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [XLEN-1:0]  alu_dataA, alu_dataB, alu_pc, alu_imm;
   logic             alu_Asel, alu_Bsel;
   logic [3:0]       alu_ALUSel;
   logic [XLEN-1:0]  alu_result;
   logic [CNT_W-1:0] op_count;

   int tests_run    = 0;
   int tests_failed = 0;

   alu_share_arbiter_if #(.XLEN(XLEN)) u_r0_if ();
   alu_share_arbiter_if #(.XLEN(XLEN)) u_r1_if ();

   alu_share_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .r0         (u_r0_if),
      .r1         (u_r1_if),
      .alu_dataA  (alu_dataA),
      .alu_dataB  (alu_dataB),
      .alu_pc     (alu_pc),
      .alu_imm    (alu_imm),
      .alu_Asel   (alu_Asel),
      .alu_Bsel   (alu_Bsel),
      .alu_ALUSel (alu_ALUSel),
      .alu_result (alu_result),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU standing in for alu_module
   logic [XLEN-1:0] w_a, w_b;
   always_comb begin
      w_a = alu_Asel ? alu_pc  : alu_dataA;
      w_b = alu_Bsel ? alu_imm : alu_dataB;
      case (alu_ALUSel)
         4'd0:    alu_result = w_a + w_b;
         4'd1:    alu_result = w_a - w_b;
         4'd2:    alu_result = w_a & w_b;
         4'd3:    alu_result = w_a | w_b;
         4'd4:    alu_result = w_a ^ w_b;
         default: alu_result = '0;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      u_r0_if.req_valid = 0; u_r0_if.dataA = 0; u_r0_if.dataB = 0; u_r0_if.pc = 0;
      u_r0_if.imm = 0; u_r0_if.Asel = 0; u_r0_if.Bsel = 0; u_r0_if.ALUSel = 0;
      u_r0_if.resp_ready = 1;
      u_r1_if.req_valid = 0; u_r1_if.dataA = 0; u_r1_if.dataB = 0; u_r1_if.pc = 0;
      u_r1_if.imm = 0; u_r1_if.Asel = 0; u_r1_if.Bsel = 0; u_r1_if.ALUSel = 0;
      u_r1_if.resp_ready = 1;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 0;
      step();
      step();
      rst_n = 1;
      #1;
   endtask

   task automatic test_reset();
      // Build up nonzero state first
      rst_n = 1;
      idle_all();
      u_r0_if.req_valid = 1; u_r0_if.dataA = 3; u_r0_if.dataB = 4;
      u_r1_if.req_valid = 1; u_r1_if.dataA = 9; u_r1_if.dataB = 1;
      u_r0_if.resp_ready = 0; u_r1_if.resp_ready = 0;
      step(); step(); step();
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      tests_run++; if (u_r0_if.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_r0_valid got=%0b exp=0", u_r0_if.resp_valid); end
      tests_run++; if (u_r1_if.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_r1_valid got=%0b exp=0", u_r1_if.resp_valid); end
      tests_run++; if (u_r0_if.resp_result !== 32'd0) begin tests_failed++; $display("FAIL rst_r0_result got=%0d exp=0", u_r0_if.resp_result); end
      tests_run++; if (u_r1_if.resp_result !== 32'd0) begin tests_failed++; $display("FAIL rst_r1_result got=%0d exp=0", u_r1_if.resp_result); end
      tests_run++; if (op_count !== 4'd0) begin tests_failed++; $display("FAIL rst_op_count got=%0d exp=0", op_count); end
      tests_run++; if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin tests_failed++; $display("FAIL rst_alu_ports got=%0d/%0d exp=0/0", alu_dataA, alu_dataB); end
      tests_run++; if (u_r0_if.req_ready !== 1'b0 || u_r1_if.req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req_ready got=%0b%0b exp=00", u_r0_if.req_ready, u_r1_if.req_ready); end
      step();
      rst_n = 1;
      #1;
      tests_run++; if (u_r0_if.req_ready !== 1'b1 || u_r1_if.req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_first_grant got=r0:%0b r1:%0b exp=r0:1 r1:0", u_r0_if.req_ready, u_r1_if.req_ready); end
      idle_all();
   endtask

   task automatic test_single_op();
      do_reset();
      u_r0_if.req_valid = 1; u_r0_if.dataA = 5; u_r0_if.dataB = 10;
      u_r0_if.Asel = 0; u_r0_if.Bsel = 0; u_r0_if.ALUSel = 0;
      #1;
      tests_run++; if (u_r0_if.req_ready !== 1'b1) begin tests_failed++; $display("FAIL single_req_ready got=%0b exp=1", u_r0_if.req_ready); end
      tests_run++; if (alu_dataA !== 32'd5 || alu_dataB !== 32'd10) begin tests_failed++; $display("FAIL single_alu_ops got=%0d/%0d exp=5/10", alu_dataA, alu_dataB); end
      step();
      u_r0_if.req_valid = 0;
      u_r0_if.resp_ready = 0;
      #1;
      tests_run++; if (u_r0_if.resp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_resp_valid got=%0b exp=1", u_r0_if.resp_valid); end
      tests_run++; if (u_r0_if.resp_result !== 32'd15) begin tests_failed++; $display("FAIL single_result got=%0d exp=15", u_r0_if.resp_result); end
      tests_run++; if (op_count !== 4'd1) begin tests_failed++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
      tests_run++; if (alu_dataA !== 32'd0 || alu_ALUSel !== 4'd0) begin tests_failed++; $display("FAIL single_idle_alu got=%0d/%0d exp=0/0", alu_dataA, alu_ALUSel); end
      idle_all();
   endtask

   task automatic test_contention();
      do_reset();
      u_r0_if.req_valid = 1; u_r0_if.dataA = 1; u_r0_if.dataB = 1; u_r0_if.ALUSel = 0;
      u_r1_if.req_valid = 1; u_r1_if.pc = 32'h100; u_r1_if.imm = 4;
      u_r1_if.Asel = 1; u_r1_if.Bsel = 1; u_r1_if.ALUSel = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         tests_run++;
         if (u_r0_if.req_ready !== ((i % 2) == 0) || u_r1_if.req_ready !== ((i % 2) == 1)) begin
            tests_failed++;
            $display("FAIL contention_grant_%0d got=r0:%0b r1:%0b exp=r0:%0b r1:%0b", i,
                     u_r0_if.req_ready, u_r1_if.req_ready, (i % 2) == 0, (i % 2) == 1);
         end
         step();
      end
      idle_all();
      tests_run++; if (op_count !== 4'd6) begin tests_failed++; $display("FAIL contention_op_count got=%0d exp=6", op_count); end
      tests_run++; if (u_r1_if.resp_result !== 32'h104) begin tests_failed++; $display("FAIL contention_r1_result got=%0h exp=104", u_r1_if.resp_result); end
      tests_run++; if (u_r0_if.resp_result !== 32'd2) begin tests_failed++; $display("FAIL contention_r0_result got=%0d exp=2", u_r0_if.resp_result); end
   endtask

   task automatic test_backpressure();
      do_reset();
      u_r0_if.req_valid = 1; u_r0_if.dataA = 7; u_r0_if.dataB = 3; u_r0_if.ALUSel = 1;
      u_r0_if.resp_ready = 0;
      step();
      u_r0_if.dataA = 20; u_r0_if.dataB = 5; u_r0_if.ALUSel = 0;
      u_r1_if.req_valid = 1; u_r1_if.dataA = 8; u_r1_if.dataB = 8; u_r1_if.ALUSel = 0;
      u_r1_if.resp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests_run++;
         if (u_r0_if.req_ready !== 1'b0 || u_r1_if.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_grant_%0d got=r0:%0b r1:%0b exp=r0:0 r1:1", i, u_r0_if.req_ready, u_r1_if.req_ready);
         end
         step();
         tests_run++;
         if (u_r0_if.resp_result !== 32'd4 || u_r0_if.resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d got=%0d/v%0b exp=4/v1", i, u_r0_if.resp_result, u_r0_if.resp_valid);
         end
      end
      u_r0_if.resp_ready = 1;
      #1;
      tests_run++; if (u_r0_if.req_ready !== 1'b1 || u_r1_if.req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_release_grant got=r0:%0b r1:%0b exp=r0:1 r1:0", u_r0_if.req_ready, u_r1_if.req_ready); end
      step();
      idle_all();
      tests_run++; if (u_r0_if.resp_result !== 32'd25) begin tests_failed++; $display("FAIL bp_release_result got=%0d exp=25", u_r0_if.resp_result); end
      tests_run++; if (u_r1_if.resp_result !== 32'd16) begin tests_failed++; $display("FAIL bp_r1_result got=%0d exp=16", u_r1_if.resp_result); end
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] exp_res [3];
      exp_res[0] = 32'h30; exp_res[1] = 32'hFC; exp_res[2] = 32'hCC;
      do_reset();
      u_r0_if.req_valid = 1; u_r0_if.dataA = 32'hF0; u_r0_if.dataB = 32'h3C;
      u_r0_if.resp_ready = 1;
      for (int i = 0; i < 3; i++) begin
         u_r0_if.ALUSel = 4'(i + 2);
         #1;
         tests_run++; if (u_r0_if.req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_%0d got=%0b exp=1", i, u_r0_if.req_ready); end
         step();
         tests_run++;
         if (u_r0_if.resp_valid !== 1'b1 || u_r0_if.resp_result !== exp_res[i]) begin
            tests_failed++;
            $display("FAIL b2b_result_%0d got=%0h/v%0b exp=%0h/v1", i, u_r0_if.resp_result, u_r0_if.resp_valid, exp_res[i]);
         end
      end
      u_r0_if.req_valid = 0;
      step();
      tests_run++; if (u_r0_if.resp_valid !== 1'b0 || u_r0_if.resp_result !== 32'hCC) begin tests_failed++; $display("FAIL b2b_drain got=%0h/v%0b exp=cc/v0", u_r0_if.resp_result, u_r0_if.resp_valid); end
      idle_all();
   endtask

   task automatic test_saturation();
      int exp_cnt;
      do_reset();
      u_r0_if.req_valid = 1; u_r0_if.dataA = 1; u_r0_if.dataB = 2;
      for (int i = 0; i < 20; i++) begin
         step();
         exp_cnt = (i + 1 > 15) ? 15 : i + 1;
         if (i == 13 || i == 14 || i == 19) begin
            tests_run++;
            if (op_count !== 4'(exp_cnt)) begin
               tests_failed++;
               $display("FAIL sat_count_%0d got=%0d exp=%0d", i + 1, op_count, exp_cnt);
            end
         end
      end
      idle_all();
   endtask

   initial begin
      rst_n = 0;
      idle_all();
      step();
      test_reset();
      test_single_op();
      test_contention();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single `alu_module` instance between two requesters.
  - Requester 0: main execute path.
  - Requester 1: address/branch-target unit.
- Uses round-robin arbitration and a valid/ready handshake.
- Drives the ALU operand/select ports (dataA, dataB, pc, imm, Asel, Bsel, ALUSel) from the granted requester.
- Captures the ALU result into a one-deep response register per requester.
- Counts granted operations for performance monitoring.

Parameters:
XLEN, 32, operand/result width
CNT_W, 16, width of saturating operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rN_req_valid  input  1  requester N (N=0,1) has an operation pending
rN_req_ready  output  1  requester N granted this cycle (handshake complete)
rN_dataA  input  XLEN  requester N register operand A
rN_dataB  input  XLEN  requester N register operand B
rN_pc  input  XLEN  requester N pc operand
rN_imm  input  XLEN  requester N immediate operand
rN_Asel  input  1  requester N A-mux select
rN_Bsel  input  1  requester N B-mux select
rN_ALUSel  input  4  requester N ALU operation code
rN_resp_valid  output  1  result for requester N held
rN_resp_ready  input  1  requester N consumes result
rN_resp_result  output  XLEN  result for requester N
alu_dataA  output  XLEN  to alu_module dataA
alu_dataB  output  XLEN  to alu_module dataB
alu_pc  output  XLEN  to alu_module pc
alu_imm  output  XLEN  to alu_module imm
alu_Asel  output  1  to alu_module Asel
alu_Bsel  output  1  to alu_module Bsel
alu_ALUSel  output  4  to alu_module ALUSel
alu_result  input  XLEN  from alu_module alu (combinational)
op_count  output  CNT_W  saturating count of grants

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Clears rN_resp_valid, rN_resp_result and op_count to 0.
  - Resets priority pointer prio to 0 (r0 favoured).
  - Any in-flight grant is discarded.
- Combinational outputs during reset: req_ready=0 and ALU ports=0.
- Eligibility: eligN = rN_req_valid && (!rN_resp_valid || rN_resp_ready).
  - A requester is ineligible while its response register is full and not being drained.
- Grant (combinational, at most one per cycle):
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester indexed by prio is granted.
  - rN_req_ready = grantN.
- Requester constraints:
  - rN_req_valid must not depend on rN_req_ready.
  - Request fields must be valid only in the handshake cycle.
- ALU ports:
  - While a grant is active, all alu_* outputs mirror the granted requester's fields.
  - When there is no grant, all alu_* outputs are 0 (ALUSel=0, Asel=0, Bsel=0).
- Priority pointer: on a grant to N, prio <= ~N at the next edge. With no grant, prio holds.
- Response register N, at each edge:
  - grantN: rN_resp_result <= alu_result; rN_resp_valid <= 1.
  - else if rN_resp_ready: rN_resp_valid <= 0; result holds its last value.
  - else: hold.
- Latency and throughput:
  - A result is visible one cycle after the handshake.
  - Sustained throughput is 1 op/cycle total.
  - A single requester can issue back-to-back if it drains every cycle, since simultaneous drain and new grant keeps valid=1 with the new data.
- The held result stays stable while rN_resp_valid=1 and rN_resp_ready=0.
- op_count:
  - Increments by 1 on any grant.
  - Saturates at 2^CNT_W-1 with no wrap.
- rN_resp_ready while rN_resp_valid=0 is ignored.

Test Plan:
1. Reset:
   - Stimulus: assert rst_n=0 mid-cycle with both requesters active.
   - Required: all resp_valid=0, results=0, op_count=0 immediately (asynchronous); alu_* = 0; first grant after release goes to r0.
2. Single op:
   - Stimulus: r0 requests dataA=5, dataB=10, Asel=0, Bsel=0, ALUSel=0 (add); r1 idle.
   - Required: r0_req_ready=1 the same cycle; alu_dataA=5 and alu_dataB=10; next cycle r0_resp_valid=1 and r0_resp_result=15; op_count=1.
3. Contention:
   - Stimulus: both requesters hold req_valid=1 with resp_ready=1 for 6 cycles.
   - Required: grants alternate r0,r1,r0,r1,r0,r1; op_count=6.
4. Backpressure:
   - Stimulus: r0 result pending with r0_resp_ready=0; both requesters keep requesting.
   - Required: r0_req_ready=0; r1 is granted every cycle; r0_resp_result is stable.
   - Then raise r0_resp_ready: r0 is granted in that same cycle.
5. Drain+issue:
   - Stimulus: r0 alone, resp_ready=1, issuing ALUSel=2,3,4 back-to-back.
   - Required: r0_resp_valid stays 1 continuously; results update every cycle, each one cycle after its issue.
6. Saturation:
   - Stimulus: CNT_W=4, 20 consecutive grants.
   - Required: op_count stops at 15.
